// File: rtl/cla_word_sequencer.sv
// Multi-precision adder: streams one bits-wide slice per cycle through a CLA, LSB first.
// Optional MPADD_SUB_EN adds a 'sub' port selecting op_a - op_b.
module cla_word_sequencer #(
  parameter int bits  = 8,
  parameter int words = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [bits*words-1:0] op_a,
  input  logic [bits*words-1:0] op_b,
`ifdef MPADD_SUB_EN
  input  logic                  sub,
`endif
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [bits*words-1:0] sum,
  output logic                  cout
);

  localparam int W  = bits * words;
  localparam int CW = (words > 1) ? $clog2(words) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_sum;
  logic            r_cout;

  logic [bits-1:0] w_a_slice;
  logic [bits-1:0] w_b_slice;
  logic [bits-1:0] w_sum_slice;
  logic            w_cout;
  logic            w_last;
  logic [W-1:0]    w_b_in;
  logic            w_carry_in;

`ifdef MPADD_SUB_EN
  // Subtraction as a + ~b + 1; cin is ignored when sub is set.
  assign w_b_in     = sub ? ~op_b : op_b;
  assign w_carry_in = sub | cin;
`else
  assign w_b_in     = op_b;
  assign w_carry_in = cin;
`endif

  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int unsigned i = 0; i < words; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_slice = r_a[i*bits +: bits];
        w_b_slice = r_b[i*bits +: bits];
      end
    end
  end

  assign w_last = (r_cnt == CW'(words - 1));

  CLA #(.bits(bits)) u_cla (
    .A    (w_a_slice),
    .B    (w_b_slice),
    .Cin  (r_carry),
    .Sum  (w_sum_slice),
    .Cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= w_b_in;
            r_carry <= w_carry_in;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < words; i++) begin
            if (r_cnt == CW'(i)) r_sum[i*bits +: bits] <= w_sum_slice;
          end
          r_carry <= w_cout;
          if (w_last) begin
            r_cout  <= w_cout;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// Carry-lookahead adder slice: every carry is a flat sum of generate/propagate products.
module CLA #(
  parameter int bits = 8
) (
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  input  logic            Cin,
  output logic [bits-1:0] Sum,
  output logic            Cout
);

  logic [bits-1:0] w_g;
  logic [bits-1:0] w_p;
  logic [bits:0]   w_c;
  logic            w_acc;
  logic            w_prop;

  assign w_g = A & B;
  assign w_p = A ^ B;

  always_comb begin
    w_c    = '0;
    w_acc  = 1'b0;
    w_prop = 1'b0;
    w_c[0] = Cin;
    for (int unsigned i = 0; i < bits; i++) begin
      w_acc  = w_g[i];
      w_prop = w_p[i];
      for (int unsigned k = 1; k <= i; k++) begin
        w_acc  = w_acc | (w_prop & w_g[i-k]);
        w_prop = w_prop & w_p[i-k];
      end
      w_c[i+1] = w_acc | (w_prop & Cin);
    end
  end

  assign Sum  = w_p ^ w_c[bits-1:0];
  assign Cout = w_c[bits];

endmodule
